// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pkg
//  Purpose  : Shared types and constants for the Simon pattern player.
//  Revision : 1.0  initial release
// ============================================================================
package simon_pkg;

    // Player sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        ON     = 3'd3,
        GAP    = 3'd4,
        FINISH = 3'd5
    } player_state_t;

    // One colour symbol as stored in the sequence RAM
    typedef logic [1:0] colour_t;

    // All LEDs dark (active-low drive)
    localparam logic [3:0] LED_OFF_N = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/simon_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : simon_cycle_timer
//  Purpose  : Loadable down-counter with a zero flag. Load has priority over
//             counting; the count holds at zero instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module simon_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load a new terminal count or step down towards zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/simon_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pattern_player
//  Purpose  : Plays a stored colour sequence on the four game LEDs, one
//             symbol per ON_CYCLES lit period followed by OFF_CYCLES blank.
//             Optional macro SIMON_PLAYER_TONE_EN adds a per-colour tone.
//  Revision : 1.0  initial release
// ============================================================================
module simon_pattern_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int MAX_LEN    = 32,
    parameter int ADDR_W     = 5,
    parameter int LEN_W      = 6
`ifdef SIMON_PLAYER_TONE_EN
    ,
    parameter int TONE_BASE  = 50_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [1:0]        rd_data_i,
    output logic [3:0]        led_n_o,
    output logic              busy_o,
    output logic              done_o
`ifdef SIMON_PLAYER_TONE_EN
    ,
    output logic              tone_o
`endif
);

    localparam int CMAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    player_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    colour_t           sym_q, sym_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]        led_n_q, led_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic [LEN_W-1:0]  len_clamped;

    assign len_clamped = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;

    // Next-state sequencing; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        sym_d    = sym_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_clamped;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? FINISH : FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                sym_d    = rd_data_i;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(ON_CYCLES - 1);
                state_d  = ON;
            end
            ON: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(OFF_CYCLES - 1);
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    if (LEN_W'(idx_q) == (len_q - LEN_W'(1))) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything outside IDLE, including a timer expiry
        if (abort_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end

        busy_d    = (state_d == FETCH) || (state_d == LATCH) ||
                    (state_d == ON)    || (state_d == GAP);
        done_d    = (state_d == FINISH);
        led_n_d   = (state_d == ON) ? ~(4'b0001 << sym_d) : LED_OFF_N;
        rd_addr_d = (state_d == FETCH) ? idx_d : rd_addr_q;
    end

    // State and registered-output storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            sym_q     <= '0;
            rd_addr_q <= '0;
            led_n_q   <= LED_OFF_N;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            sym_q     <= sym_d;
            rd_addr_q <= rd_addr_d;
            led_n_q   <= led_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    simon_cycle_timer #(
        .WIDTH (TMR_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       ((state_q == ON) || (state_q == GAP)),
        .zero_o     (tmr_zero)
    );

    assign rd_addr_o = rd_addr_q;
    assign led_n_o   = led_n_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

`ifdef SIMON_PLAYER_TONE_EN
    localparam int TONE_W = $clog2(TONE_BASE * 4);

    logic              tone_q, tone_d;
    logic              tone_load;
    logic [TONE_W-1:0] tone_val;
    logic              tone_zero;

    // Half-period divider: restarts on ON entry, toggles the tone each time it expires
    always_comb begin
        tone_d    = tone_q;
        tone_load = 1'b0;
        tone_val  = '0;
        if (state_d != ON) begin
            tone_d = 1'b0;
        end else if (state_q == LATCH) begin
            tone_d    = 1'b0;
            tone_load = 1'b1;
            tone_val  = TONE_W'(TONE_BASE * (int'(rd_data_i) + 1) - 1);
        end else if (tone_zero) begin
            tone_d    = ~tone_q;
            tone_load = 1'b1;
            tone_val  = TONE_W'(TONE_BASE * (int'(sym_q) + 1) - 1);
        end
    end

    // Tone output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_q <= 1'b0;
        end else begin
            tone_q <= tone_d;
        end
    end

    simon_cycle_timer #(
        .WIDTH (TONE_W)
    ) u_tone_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tone_load),
        .load_val_i (tone_val),
        .en_i       (state_q == ON),
        .zero_o     (tone_zero)
    );

    assign tone_o = tone_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simon_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_pattern_player
//  Purpose  : Directed self-checking bench for simon_pattern_player with
//             ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_simon_pattern_player;

    localparam int ON_C   = 4;
    localparam int OFF_C  = 2;
    localparam int PERIOD = ON_C + OFF_C + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       abort_i;
    logic [3:0] len_i;
    logic [2:0] rd_addr_o;
    logic [1:0] rd_data_i;
    logic [3:0] led_n_o;
    logic       busy_o;
    logic       done_o;

    logic [1:0] ram [8];

    int n_vec  = 0;
    int n_miss = 0;

    simon_pattern_player #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .MAX_LEN    (8),
        .ADDR_W     (3),
        .LEN_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .len_i     (len_i),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .led_n_o   (led_n_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    // Sequence RAM with one cycle of read latency
    always @(posedge clk) rd_data_i <= ram[rd_addr_o];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] led_for(input logic [1:0] s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << s);
    endfunction

    // Expected outputs in cycle c after the start edge for an n-symbol playback
    task automatic expect_cycle(input int c, input int n);
        int s, p;
        logic [3:0] el;
        if (c <= PERIOD * n) begin
            s  = (c - 1) / PERIOD;
            p  = (c - 1) % PERIOD;
            el = (p >= 2 && p <= 1 + ON_C) ? led_for(ram[s[2:0]]) : 4'hF;
            chk($sformatf("led c%0d", c),  32'(led_n_o),   32'(el));
            chk($sformatf("busy c%0d", c), 32'(busy_o),    32'd1);
            chk($sformatf("done c%0d", c), 32'(done_o),    32'd0);
            chk($sformatf("addr c%0d", c), 32'(rd_addr_o), 32'(s));
        end else begin
            chk($sformatf("led c%0d", c),  32'(led_n_o), 32'hF);
            chk($sformatf("busy c%0d", c), 32'(busy_o),  32'd0);
            chk($sformatf("done c%0d", c), 32'(done_o),  32'(c == PERIOD * n + 1));
        end
    endtask

    // Start a playback and check every cycle through completion
    task automatic play(input int len, input int n, input bit inject, input bit with_abort);
        start_i = 1'b1;
        abort_i = with_abort;
        len_i   = 4'(len);
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        for (int c = 1; c <= PERIOD * n + 2; c++) begin
            expect_cycle(c, n);
            start_i = inject && (c == 2 || c == 10);
            if (c < PERIOD * n + 2) tick();
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        len_i   = '0;
        for (int i = 0; i < 8; i++) ram[i] = 2'd0;
        tick();
        tick();
        chk("rst led",  32'(led_n_o),   32'hF);
        chk("rst busy", 32'(busy_o),    32'd0);
        chk("rst done", 32'(done_o),    32'd0);
        chk("rst addr", 32'(rd_addr_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero length: done in cycle 1, no busy, address untouched
        play(0, 0, 1'b0, 1'b0);
        chk("len0 addr", 32'(rd_addr_o), 32'd0);

        // Three symbols 2,0,3
        ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
        play(3, 3, 1'b0, 1'b0);

        // Over-length request clamps to eight symbols of colour 1
        for (int i = 0; i < 8; i++) ram[i] = 2'd1;
        play(12, 8, 1'b0, 1'b0);

        // Abort in the ON phase of the second symbol
        ram[0] = 2'd1; ram[1] = 2'd2; ram[2] = 2'd3; ram[3] = 2'd0;
        start_i = 1'b1;
        len_i   = 4'd4;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            expect_cycle(c, 4);
            if (c < 12) tick();
        end
        chk("abort pre led", 32'(led_n_o), 32'hB);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort led %0d", k),  32'(led_n_o), 32'hF);
            chk($sformatf("abort busy %0d", k), 32'(busy_o),  32'd0);
            chk($sformatf("abort done %0d", k), 32'(done_o),  32'd0);
            tick();
        end
        // Start and abort together in IDLE: start wins, replay from index 0
        play(1, 1, 1'b0, 1'b1);

        // Extra starts while busy are ignored
        ram[0] = 2'd3; ram[1] = 2'd2;
        play(2, 2, 1'b1, 1'b0);

        // Asynchronous reset in the ON phase of the second symbol
        start_i = 1'b1;
        len_i   = 4'd3;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            expect_cycle(c, 3);
            if (c < 12) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst led",  32'(led_n_o),   32'hF);
        chk("arst busy", 32'(busy_o),    32'd0);
        chk("arst done", 32'(done_o),    32'd0);
        chk("arst addr", 32'(rd_addr_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_pattern_player.md
Name: simon_pattern_player

Overview:
- Plays a stored colour sequence back on the four game LEDs. This is the output-side counterpart to the key synchroniser: keys come in, LED cues go out.
- Fetches 2-bit colour symbols from the sequence RAM over a 1-cycle-latency read port.
- Lights one LED per symbol for a fixed on-time, then holds a blank gap before the next symbol.
- Controlled by the game FSM through a start/busy/done handshake, with abort.

Parameters:
- ON_CYCLES, 25_000_000, clock cycles each LED stays lit; must be ≥1.
- OFF_CYCLES, 12_500_000, blank cycles after each symbol; must be ≥1.
- MAX_LEN, 32, maximum sequence length; must be a power of two.
- ADDR_W, 5, equal to log2(MAX_LEN).
- LEN_W, 6, width of len; must hold MAX_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin playback; sampled only in IDLE.
- abort  in  1  stops playback immediately; done is not pulsed.
- len  in  LEN_W  number of symbols to play; sampled on the start cycle.
- rd_addr  out  ADDR_W  sequence RAM address (registered).
- rd_data  in  2  colour symbol; valid one cycle after rd_addr is presented.
- led_n  out  4  active-low LED drive, same polarity as the board keys.
- busy  out  1  high from the cycle after start until done or abort.
- done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Reset (async assert, sync deassert by the system) forces:
  - state = IDLE; led_n = 4'b1111; busy = 0; done = 0; rd_addr = 0; index and timer = 0.
- States: IDLE, FETCH, LATCH, ON, GAP, FINISH.
- IDLE:
  - On start=1, register len_q = min(len, MAX_LEN), idx = 0.
  - If len_q == 0, go to FINISH; otherwise go to FETCH.
- FETCH (1 cycle): rd_addr = idx; led_n = 4'b1111.
- LATCH (1 cycle): capture sym = rd_data at the clock edge ending this cycle; load timer = ON_CYCLES-1.
- ON:
  - led_n = ~(4'b0001 << sym).
  - Exactly one LED is low for exactly ON_CYCLES cycles.
  - At timer == 0, load timer = OFF_CYCLES-1 and go to GAP.
- GAP:
  - led_n = 4'b1111 for exactly OFF_CYCLES cycles.
  - At timer == 0: if idx == len_q-1, go to FINISH; else idx++ and go to FETCH.
- FINISH (1 cycle): done = 1, busy = 0 next cycle, then return to IDLE.
- Latency:
  - start sampled at edge k.
  - busy = 1 and rd_addr valid in cycle k+1.
  - First LED low from cycle k+3.
  - Per-symbol period = ON_CYCLES + OFF_CYCLES + 2.
- busy:
  - Registered; high in FETCH, LATCH, ON and GAP.
  - Low in IDLE and FINISH.
- start while busy: ignored; no queuing.
- abort:
  - Accepted in any non-IDLE state.
  - Next cycle: state = IDLE, led_n = 4'b1111, busy = 0, no done pulse.
  - abort takes priority over a coincident timer expiry.
  - abort in IDLE has no effect.
- start and abort in the same IDLE cycle: start wins, because abort is meaningless in IDLE.
- len > MAX_LEN: clamped to MAX_LEN; the address never exceeds MAX_LEN-1.
- Timers are down-counters sized $clog2(max(ON_CYCLES, OFF_CYCLES)); no wrap-around is possible.
- led_n is driven from a register; it never glitches and never has two LEDs low at once.

Optional Feature:
- Macro: SIMON_PLAYER_TONE_EN.
- When defined:
  - Adds output port tone (1 bit) and parameter TONE_BASE (default 50_000).
  - During ON, tone toggles every TONE_BASE*(sym+1) cycles, giving a distinct pitch per colour.
  - tone = 0 in every other state, at reset and on abort.
  - The tone divider restarts at 0 on entry to ON.
- When undefined: the tone port and divider logic are absent; all other behaviour is identical.

Decomposition:
- Package simon_pkg holds:
  - state enum player_state_t (IDLE, FETCH, LATCH, ON, GAP, FINISH);
  - typedef colour_t (2 bits) and LED constants LED_OFF_N = 4'b1111.
- One sub-module is natural: simon_cycle_timer, a loadable down-counter with a zero flag. It is reused for the on/gap timing and for the tone divider.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=8):
- len=3, RAM={2,0,3}, start pulse at edge 0:
  - led_n = 1011 for cycles 3–6, then 1111 for cycles 7–8;
  - then 1110 for cycles 11–14, then 0111;
  - done pulses once; busy covers cycles 1 through the end of the last GAP.
- len=0 with start: no LED activity and no rd_addr change; done pulses in cycle 1; busy stays 0.
- len=12 (> MAX_LEN), RAM filled with 1s:
  - exactly 8 symbols play, each led_n = 1101;
  - rd_addr runs 0..7 with no wrap.
- abort during symbol 2 ON:
  - next cycle led_n = 1111 and busy = 0; no done pulse;
  - a new start then plays from idx 0.
- start pulses while busy, plus rst_n asserted mid-ON:
  - extra starts are ignored;
  - on reset, outputs take their reset values immediately, with no clock edge needed.
- With SIMON_PLAYER_TONE_EN and TONE_BASE=2, sym=3: tone toggles every 8 cycles during ON and is 0 during GAP.
